rrx_axi_read_arbiter: RTL and testbench

Two-master to one-slave arbiter for the AXI read path (AR and R channels) of the Rasterix memory port. It lets two read clients share the single `axi_ram` / DDR read port that `RasterixIF` drives, for example texture fetch and framebuffer scan-out. Each master is granted a whole burst: one AR handshake, then its R beats through `rlast`. The write channels (AW/W/B) are not touched by this block.

---
 rtl/rrx_axi_read_arbiter.sv | 139 +++++++++++++
 tb/tb_rrx_axi_read_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rrx_axi_read_arbiter.sv
// Two-master to one-slave AXI read (AR/R) arbiter with one outstanding burst per grant.
// Define RRX_AXI_READ_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority (master 0).
module rrx_axi_read_arbiter #(
    parameter int ID_WIDTH   = 8,
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  aclk,
    input  logic                  resetn,

    input  logic [ID_WIDTH-1:0]   s0_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic [7:0]            s0_axi_arlen,
    input  logic [2:0]            s0_axi_arsize,
    input  logic [1:0]            s0_axi_arburst,
    input  logic                  s0_axi_arvalid,
    output logic                  s0_axi_arready,
    output logic [ID_WIDTH-1:0]   s0_axi_rid,
    output logic [DATA_WIDTH-1:0] s0_axi_rdata,
    output logic [1:0]            s0_axi_rresp,
    output logic                  s0_axi_rlast,
    output logic                  s0_axi_rvalid,
    input  logic                  s0_axi_rready,

    input  logic [ID_WIDTH-1:0]   s1_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
    input  logic [7:0]            s1_axi_arlen,
    input  logic [2:0]            s1_axi_arsize,
    input  logic [1:0]            s1_axi_arburst,
    input  logic                  s1_axi_arvalid,
    output logic                  s1_axi_arready,
    output logic [ID_WIDTH-1:0]   s1_axi_rid,
    output logic [DATA_WIDTH-1:0] s1_axi_rdata,
    output logic [1:0]            s1_axi_rresp,
    output logic                  s1_axi_rlast,
    output logic                  s1_axi_rvalid,
    input  logic                  s1_axi_rready,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic                  grant,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0] state;
    logic       last_grant;
    logic       any_req;
    logic       winner;
    logic       in_addr;
    logic       in_data;

    assign any_req = s0_axi_arvalid | s1_axi_arvalid;
    assign in_addr = (state == ST_ADDR);
    assign in_data = (state == ST_DATA);
    assign busy    = in_addr | in_data;

    // winner is only consumed when a request is pending, so the no-request value is free
    always_comb begin
`ifdef RRX_AXI_READ_ARB_ROUND_ROBIN_EN
        if (s0_axi_arvalid && s1_axi_arvalid) begin
            winner = ~last_grant;
        end else begin
            winner = ~s0_axi_arvalid;
        end
`else
        winner = s0_axi_arvalid ? 1'b0 : (s1_axi_arvalid | last_grant);
`endif
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant <= winner;
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_axi_arvalid && m_axi_arready) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // AR path: payload is zeroed outside ADDR so nothing leaks to the slave while idle
    assign m_axi_arvalid  = in_addr & (grant ? s1_axi_arvalid : s0_axi_arvalid);
    assign m_axi_arid     = in_addr ? (grant ? s1_axi_arid    : s0_axi_arid)    : '0;
    assign m_axi_araddr   = in_addr ? (grant ? s1_axi_araddr  : s0_axi_araddr)  : '0;
    assign m_axi_arlen    = in_addr ? (grant ? s1_axi_arlen   : s0_axi_arlen)   : '0;
    assign m_axi_arsize   = in_addr ? (grant ? s1_axi_arsize  : s0_axi_arsize)  : '0;
    assign m_axi_arburst  = in_addr ? (grant ? s1_axi_arburst : s0_axi_arburst) : '0;
    assign s0_axi_arready = in_addr & ~grant & m_axi_arready;
    assign s1_axi_arready = in_addr &  grant & m_axi_arready;

    // R path: payload broadcast, handshake only with the owner during DATA
    assign m_axi_rready  = in_data & (grant ? s1_axi_rready : s0_axi_rready);
    assign s0_axi_rvalid = in_data & ~grant & m_axi_rvalid;
    assign s1_axi_rvalid = in_data &  grant & m_axi_rvalid;

    assign s0_axi_rid   = m_axi_rid;
    assign s0_axi_rdata = m_axi_rdata;
    assign s0_axi_rresp = m_axi_rresp;
    assign s0_axi_rlast = m_axi_rlast;
    assign s1_axi_rid   = m_axi_rid;
    assign s1_axi_rdata = m_axi_rdata;
    assign s1_axi_rresp = m_axi_rresp;
    assign s1_axi_rlast = m_axi_rlast;

endmodule

// File: tb/tb_rrx_axi_read_arbiter.sv
// Cycle-vector bench for rrx_axi_read_arbiter; expectations follow RRX_AXI_READ_ARB_ROUND_ROBIN_EN.
module tb_rrx_axi_read_arbiter;

    logic aclk = 1'b0;
    logic resetn;
    always #5 aclk = ~aclk;

    logic [7:0]  s0_axi_arid, s1_axi_arid, m_axi_arid;
    logic [24:0] s0_axi_araddr, s1_axi_araddr, m_axi_araddr;
    logic [7:0]  s0_axi_arlen, s1_axi_arlen, m_axi_arlen;
    logic [2:0]  s0_axi_arsize, s1_axi_arsize, m_axi_arsize;
    logic [1:0]  s0_axi_arburst, s1_axi_arburst, m_axi_arburst;
    logic        s0_axi_arvalid, s1_axi_arvalid, m_axi_arvalid;
    logic        s0_axi_arready, s1_axi_arready, m_axi_arready;
    logic [7:0]  s0_axi_rid, s1_axi_rid, m_axi_rid;
    logic [63:0] s0_axi_rdata, s1_axi_rdata, m_axi_rdata;
    logic [1:0]  s0_axi_rresp, s1_axi_rresp, m_axi_rresp;
    logic        s0_axi_rlast, s1_axi_rlast, m_axi_rlast;
    logic        s0_axi_rvalid, s1_axi_rvalid, m_axi_rvalid;
    logic        s0_axi_rready, s1_axi_rready, m_axi_rready;
    logic        grant, busy;

    rrx_axi_read_arbiter #(.ID_WIDTH(8), .ADDR_WIDTH(25), .DATA_WIDTH(64)) dut (
        .aclk(aclk), .resetn(resetn),
        .s0_axi_arid(s0_axi_arid), .s0_axi_araddr(s0_axi_araddr), .s0_axi_arlen(s0_axi_arlen),
        .s0_axi_arsize(s0_axi_arsize), .s0_axi_arburst(s0_axi_arburst),
        .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
        .s0_axi_rid(s0_axi_rid), .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
        .s0_axi_rlast(s0_axi_rlast), .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready),
        .s1_axi_arid(s1_axi_arid), .s1_axi_araddr(s1_axi_araddr), .s1_axi_arlen(s1_axi_arlen),
        .s1_axi_arsize(s1_axi_arsize), .s1_axi_arburst(s1_axi_arburst),
        .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
        .s1_axi_rid(s1_axi_rid), .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
        .s1_axi_rlast(s1_axi_rlast), .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .grant(grant), .busy(busy)
    );

    // ctl bit order: {grant, busy, m_arvalid, m_rready, s0_arready, s1_arready, s0_rvalid, s1_rvalid}
    typedef struct {
        logic        s0v, s1v, arr, rv, rl, s0rr, s1rr;
        logic [7:0]  exp_ctl;
        logic [24:0] exp_addr;
        logic [7:0]  exp_id;
    } vec_t;

    localparam logic [7:0] C_IDLE0  = 8'b0000_0000;
    localparam logic [7:0] C_IDLE1  = 8'b1000_0000;
    localparam logic [7:0] C_ADDR0S = 8'b0110_0000;
    localparam logic [7:0] C_ADDR0  = 8'b0110_1000;
    localparam logic [7:0] C_ADDR1  = 8'b1110_0100;
    localparam logic [7:0] C_DATA0  = 8'b0101_0010;
    localparam logic [7:0] C_DATA0S = 8'b0100_0010;
    localparam logic [7:0] C_DATA1  = 8'b1101_0001;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(input logic s0v, input logic s1v, input logic arr, input logic rv,
                                input logic rl, input logic s0rr, input logic s1rr,
                                input logic [7:0] c, input logic [24:0] a, input logic [7:0] id);
        vec_t v;
        v.s0v = s0v; v.s1v = s1v; v.arr = arr; v.rv = rv; v.rl = rl; v.s0rr = s0rr; v.s1rr = s1rr;
        v.exp_ctl = c; v.exp_addr = a; v.exp_id = id;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ctl_now();
        return {grant, busy, m_axi_arvalid, m_axi_rready,
                s0_axi_arready, s1_axi_arready, s0_axi_rvalid, s1_axi_rvalid};
    endfunction

    task automatic drive(input logic s0v, input logic s1v, input logic arr, input logic rv,
                         input logic rl, input logic s0rr, input logic s1rr);
        s0_axi_arvalid = s0v; s1_axi_arvalid = s1v; m_axi_arready = arr;
        m_axi_rvalid = rv; m_axi_rlast = rl; s0_axi_rready = s0rr; s1_axi_rready = s1rr;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic g_k, prev;

        s0_axi_arid = 8'h11; s0_axi_araddr = 25'h100; s0_axi_arlen = 8'd3;
        s0_axi_arsize = 3'd3; s0_axi_arburst = 2'd1;
        s1_axi_arid = 8'h22; s1_axi_araddr = 25'h200; s1_axi_arlen = 8'd0;
        s1_axi_arsize = 3'd3; s1_axi_arburst = 2'd1;
        m_axi_rid = 8'h00; m_axi_rdata = '0; m_axi_rresp = 2'd0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // single burst from master 0, arlen 3
        add(1,0,0,0,0,0,0, C_IDLE0, 25'h0, 8'h0);
        add(1,0,1,0,0,0,0, C_ADDR0, 25'h100, 8'h11);
        for (int b = 0; b < 3; b++) add(0,0,0,1,0,1,0, C_DATA0, 25'h0, 8'h0);
        add(0,0,0,1,1,1,0, C_DATA0, 25'h0, 8'h0);
        add(0,0,0,0,0,0,0, C_IDLE0, 25'h0, 8'h0);
        // slave AR backpressure for 5 cycles, then master R backpressure
        add(1,0,0,0,0,0,0, C_IDLE0, 25'h0, 8'h0);
        for (int b = 0; b < 5; b++) add(1,0,0,0,0,0,0, C_ADDR0S, 25'h100, 8'h11);
        add(1,0,1,0,0,0,0, C_ADDR0, 25'h100, 8'h11);
        add(0,0,0,1,0,0,0, C_DATA0S, 25'h0, 8'h0);
        add(0,0,0,1,1,1,0, C_DATA0, 25'h0, 8'h0);
        // stray R beat while idle, held until master 1's burst reaches DATA
        add(0,0,0,1,0,0,0, C_IDLE0, 25'h0, 8'h0);
        add(0,0,0,1,0,0,0, C_IDLE0, 25'h0, 8'h0);
        add(0,1,0,1,0,0,0, C_IDLE0, 25'h0, 8'h0);
        add(0,1,1,1,0,0,0, C_ADDR1, 25'h200, 8'h22);
        add(0,0,0,1,1,0,1, C_DATA1, 25'h0, 8'h0);
        add(0,0,0,0,0,0,0, C_IDLE1, 25'h0, 8'h0);
        // simultaneous single-beat requests; last_grant is 1 here
        prev = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef RRX_AXI_READ_ARB_ROUND_ROBIN_EN
            g_k = k[0];
`else
            g_k = 1'b0;
`endif
            add(1,1,0,0,0,1,1, {prev, 7'b0}, 25'h0, 8'h0);
            add(1,1,1,0,0,1,1, g_k ? C_ADDR1 : C_ADDR0, g_k ? 25'h200 : 25'h100, g_k ? 8'h22 : 8'h11);
            add(1,1,0,1,1,1,1, g_k ? C_DATA1 : C_DATA0, 25'h0, 8'h0);
            prev = g_k;
        end
        // master 0 goes quiet: master 1 is served
        add(0,1,0,0,0,1,1, {prev, 7'b0}, 25'h0, 8'h0);
        add(0,1,1,0,0,1,1, C_ADDR1, 25'h200, 8'h22);
        add(0,1,0,1,1,1,1, C_DATA1, 25'h0, 8'h0);
        add(0,0,0,0,0,0,0, C_IDLE1, 25'h0, 8'h0);

        // reset state
        resetn = 1'b0;
        repeat (2) @(negedge aclk);
        #1;
        check("reset ctl", 64'(ctl_now()), 64'(C_IDLE0));
        check("reset araddr", 64'(m_axi_araddr), 64'h0);
        check("reset arid", 64'(m_axi_arid), 64'h0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            @(negedge aclk);
            drive(vecs[i].s0v, vecs[i].s1v, vecs[i].arr, vecs[i].rv,
                  vecs[i].rl, vecs[i].s0rr, vecs[i].s1rr);
            m_axi_rdata = 64'(i);
            #1;
            check($sformatf("vec%0d ctl", i), 64'(ctl_now()), 64'(vecs[i].exp_ctl));
            check($sformatf("vec%0d araddr", i), 64'(m_axi_araddr), 64'(vecs[i].exp_addr));
            check($sformatf("vec%0d arid", i), 64'(m_axi_arid), 64'(vecs[i].exp_id));
        end

        // reset mid-burst: master 0 burst of 8, reset after beat 2
        s0_axi_arlen = 8'd7;
        @(negedge aclk); drive(1,0,0,0,0,0,0);
        @(negedge aclk); drive(1,0,1,0,0,0,0);
        #1; check("mid addr ctl", 64'(ctl_now()), 64'(C_ADDR0));
        check("mid arlen", 64'(m_axi_arlen), 64'd7);
        for (int b = 0; b < 2; b++) begin
            @(negedge aclk); drive(0,0,0,1,0,1,0);
            m_axi_rdata = 64'hA5A5_0000_0000_0000 + 64'(b);
            m_axi_rid = 8'h11;
            #1;
            check($sformatf("mid beat%0d ctl", b), 64'(ctl_now()), 64'(C_DATA0));
            check($sformatf("mid beat%0d rdata", b), s0_axi_rdata, 64'hA5A5_0000_0000_0000 + 64'(b));
        end
        @(negedge aclk); drive(1,0,1,1,0,1,0);
        #2; resetn = 1'b0;
        #1;
        check("async reset ctl", 64'(ctl_now()), 64'(C_IDLE0));
        check("async reset araddr", 64'(m_axi_araddr), 64'h0);
        @(negedge aclk); drive(0,0,0,0,0,0,0);
        resetn = 1'b1;
        @(negedge aclk); drive(0,1,0,0,0,0,0);
        #1; check("post reset idle", 64'(ctl_now()), 64'(C_IDLE0));
        @(negedge aclk); drive(0,1,1,0,0,0,0);
        #1; check("post reset addr", 64'(ctl_now()), 64'(C_ADDR1));
        check("post reset araddr", 64'(m_axi_araddr), 64'h200);
        @(negedge aclk); drive(0,0,0,1,1,0,1);
        m_axi_rdata = 64'h0000_CAFE_F00D_0001; m_axi_rid = 8'h22;
        #1; check("post reset data", 64'(ctl_now()), 64'(C_DATA1));
        check("post reset rdata", s1_axi_rdata, 64'h0000_CAFE_F00D_0001);
        check("post reset rid", 64'(s1_axi_rid), 64'h22);
        @(negedge aclk); drive(0,0,0,0,0,0,0);
        #1; check("post reset back idle", 64'(ctl_now()), 64'(C_IDLE1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
